// File: rtl/bcd_hex_display.sv
// Binary-to-decimal display stage: double-dabble converter plus 7-segment encoder. Option: LEADING_ZERO_BLANK_EN.
// Latency: Start accepted at edge k -> HEX*/Done update at edge k+WIDTH+1; Busy high meanwhile.
// Backpressure: none; Start is ignored (not queued) while Busy, Value is captured only on acceptance.
module bcd_hex_display #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 6
) (
  input  logic             Clk,
  input  logic             Reset_Clear,
  input  logic             Start,
  input  logic [WIDTH-1:0] Value,
  output logic             Busy,
  output logic             Done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q, bcd_adj;
  logic [6:0]          seg   [DIGITS];
  logic [6:0]          hex_q [DIGITS];

  function automatic logic [6:0] enc(input logic [3:0] nib);
    case (nib)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b0111111;
    endcase
  endfunction

  // All nibbles are corrected in parallel before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin : seg_blank
    logic seen;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen   = seen | (bcd_q[4*i +: 4] != 4'd0);
      seg[i] = (seen || i == 0) ? enc(bcd_q[4*i +: 4]) : SEG_BLANK;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      seg[i] = enc(bcd_q[4*i +: 4]);
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_Clear) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_Clear) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      Done  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
        hex_q[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
`else
        hex_q[i] <= SEG_ZERO;
`endif
      end
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            bin_q <= Value;
            bcd_q <= '0;
            cnt_q <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q - CNT_W'(1);
        end
        LATCH: begin
          hex_q <= seg;
          Done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state_q != IDLE);

  // Six physical displays; DIGITS is expected to be at least 6.
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_bcd_hex_display.sv
// Bench for bcd_hex_display: directed vector table plus hand-written multi-cycle sequences.
module tb_bcd_hex_display;

  logic        Clk = 1'b0;
  logic        Reset_Clear;
  logic        Start;
  logic [16:0] Value;
  logic        Busy, Done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0] hex_bus;

  int checks   = 0;
  int failures = 0;

  bcd_hex_display #(.WIDTH(17), .DIGITS(6)) dut (
    .Clk(Clk), .Reset_Clear(Reset_Clear), .Start(Start), .Value(Value),
    .Busy(Busy), .Done(Done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 Clk = ~Clk;
  assign hex_bus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  typedef struct {
    logic [16:0] value;
    logic [23:0] digits;  // expected decimal digits, one nibble per display
  } vec_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b1000000;  4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;  4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;  4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;  4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;  4'd9: seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] d);
    logic [41:0] r;
    logic seen;
    seen = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      r[7*i +: 7] = seg_of(d[4*i +: 4]);
      seen = seen | (d[4*i +: 4] != 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
      if (!seen && i != 0) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge; returns at the negedge where Done is seen.
  task automatic wait_done(input logic [41:0] hold, output int busy_n, output bit glitch);
    busy_n = 0;
    glitch = 1'b0;
    for (int c = 0; c < 40 && !Done; c++) begin
      if (Busy) busy_n++;
      if (hex_bus !== hold) glitch = 1'b1;
      @(negedge Clk);
    end
  endtask

  task automatic pulse_start(input logic [16:0] v);
    Start = 1'b1;
    Value = v;
    @(negedge Clk);
    Start = 1'b0;
    Value = 17'h1ABCD;
  endtask

  task automatic run_conv(input string name, input logic [16:0] v, input logic [23:0] digs,
                          inout logic [41:0] shown);
    int busy_n;
    bit glitch;
    pulse_start(v);
    wait_done(shown, busy_n, glitch);
    chk({name, "_done"},     Done,    1);
    chk({name, "_busy_len"}, busy_n,  18);
    chk({name, "_no_glitch"}, glitch, 0);
    chk({name, "_hex"},      hex_bus, exp_hex(digs));
    shown = exp_hex(digs);
    @(negedge Clk);
    chk({name, "_done_1cyc"}, Done, 0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [41:0] shown;
    int          busy_n, gap, extra;
    bit          glitch;

    vecs[0] = '{17'd288,    24'h000288};
    vecs[1] = '{17'd131071, 24'h131071};
    vecs[2] = '{17'd0,      24'h000000};
    vecs[3] = '{17'd99999,  24'h099999};
    vecs[4] = '{17'd100000, 24'h100000};
    vecs[5] = '{17'd65536,  24'h065536};
    vecs[6] = '{17'd10,     24'h000010};
    vecs[7] = '{17'd9,      24'h000009};

    Reset_Clear = 1'b0;
    Start       = 1'b0;
    Value       = '0;
    repeat (2) @(negedge Clk);
    Reset_Clear = 1'b1;
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_hex",  hex_bus, exp_hex(24'h0));
    shown = exp_hex(24'h0);
    @(negedge Clk);

    foreach (vecs[i]) run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].digits, shown);

    // Start during a conversion is dropped, not queued.
    pulse_start(17'd288);
    repeat (4) @(negedge Clk);
    pulse_start(17'd83);
    wait_done(shown, busy_n, glitch);
    chk("ign_done", Done, 1);
    chk("ign_hex",  hex_bus, exp_hex(24'h000288));
    shown = exp_hex(24'h000288);
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge Clk);
      if (Done) extra++;
    end
    chk("ign_not_queued", extra, 0);
    run_conv("fresh83", 17'd83, 24'h000083, shown);

    // Start held high: a new capture happens in the Done cycle, so Done repeats every 19 clocks.
    Start = 1'b1;
    Value = 17'd500;
    @(negedge Clk);
    wait_done(shown, busy_n, glitch);
    chk("b2b_first_hex", hex_bus, exp_hex(24'h000500));
    Value = 17'd777;
    gap = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      gap++;
      if (Done) break;
    end
    Start = 1'b0;
    chk("b2b_gap", gap, 19);
    chk("b2b_second_hex", hex_bus, exp_hex(24'h000777));
    shown = exp_hex(24'h000777);
    repeat (3) @(negedge Clk);
    chk("b2b_idle", Busy, 0);

    // Reset mid-SHIFT aborts: idle at once, reset display, no Done afterwards.
    pulse_start(17'd12345);
    repeat (5) @(negedge Clk);
    chk("abort_busy_before", Busy, 1);
    Reset_Clear = 1'b0;
    @(negedge Clk);
    Reset_Clear = 1'b1;
    chk("abort_busy", Busy, 0);
    chk("abort_hex",  hex_bus, exp_hex(24'h0));
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      if (Done || Busy) extra++;
      @(negedge Clk);
    end
    chk("abort_no_done", extra, 0);
    shown = exp_hex(24'h0);
    run_conv("post_abort", 17'd4096, 24'h004096, shown);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
